control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter N, default 32, width of imm output; matches the ALU operand width.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 instr_valid  input  1  upstream has an instruction on instr.
REQ-005 instr  input  32  fields: op[31:27], rd[26:23], rs1[22:19], rs2[18:15], imm15[14:0].
REQ-006 instr_ready  output  1  block can accept an instruction this cycle.
REQ-007 flags  input  4  registered ALU flags: bit 3 Z, bit 2 N, bit 1 C, bit 0 V.
REQ-008 alu_ctrl  output  5  ALU operation code.
REQ-009 rd_addr / rs1_addr / rs2_addr  output  4 each  register-file addresses.
REQ-010 imm  output  N  imm15 sign-extended to N bits.
REQ-011 alu_src_imm  output  1  ALU src_B takes imm instead of rs2.
REQ-012 reg_we  output  1  register-file write enable.
REQ-013 mem_req  output  1  data-memory request; mem_we  output  1  request is a store.
REQ-014 mem_ack  input  1  memory completed the request.
REQ-015 pc_load  output  1  branch taken; PC loads the branch target.
REQ-016 err  output  1  one-cycle pulse: illegal opcode or memory timeout.

Function
REQ-017 Legal op: 1 ADD, 2 SUB, 3 MUL, 4 MOV, 9 AND, 10 OR, 11 XOR, 12 NOT, 17 LDR, 19 STR, 25 JE, 26 JNE, 27 JGT, 28 JGE, 29 JLT, 30 JLE.
REQ-018 FSM states: IDLE, EXEC, MEM, WB. instr_ready=1 only in IDLE.
REQ-019 Accept on instr_valid && instr_ready; latch instr. Legal op -> EXEC. Illegal op -> err=1 next cycle, stay in IDLE, no other side effects.
REQ-020 EXEC lasts 1 cycle; alu_ctrl=op. Outside EXEC/MEM/WB, alu_ctrl=0.
REQ-021 rd/rs1/rs2/imm are driven from the latched fields and held stable from EXEC through WB.
REQ-022 alu_src_imm=1 for ops 17, 19 and 25-30; 0 otherwise.
REQ-023 ALU ops: EXEC -> WB. LDR/STR: EXEC -> MEM. Jumps: EXEC -> IDLE.
REQ-024 Jumps evaluate flags in EXEC; pc_load=1 for that cycle only when taken:
- JE: Z
- JNE: !Z
- JGT: !Z && N==V
- JGE: N==V
- JLT: N!=V
- JLE: Z || N!=V
REQ-025 MEM: mem_req=1 (mem_we=1 for STR) until mem_ack=1 is sampled; then STR -> IDLE, LDR -> WB. mem_ack is ignored outside MEM.
REQ-026 WB lasts 1 cycle; reg_we=1 unless rd=0 (r0 hard-wired, write suppressed); then -> IDLE.
REQ-027 Latency (accept at edge 0):
- ALU op: EXEC in cycle 1, WB in cycle 2, instr_ready=1 in cycle 3.
- Jump: instr_ready=1 in cycle 2.
REQ-028 imm[N-1:15] = imm15[14].

Reset
REQ-029 While rst=1, all outputs are 0 (including instr_ready) and the FSM is in IDLE; instr_ready=1 in the first cycle after release.
REQ-030 rst asserted mid-operation drops mem_req/reg_we/pc_load immediately; the in-flight instruction is discarded.

Configuration
REQ-031 Macro CTRL_MEM_TIMEOUT_EN defined:
- 4-bit counter runs in MEM.
- No mem_ack within 16 MEM cycles -> mem_req drops, err pulses 1 cycle, FSM -> IDLE, no WB.
REQ-032 Macro undefined: no counter; MEM waits indefinitely for mem_ack.

Verification
REQ-033 ADD op=1 rd=3 rs1=1 rs2=2 -> alu_ctrl=1 in cycle 1; reg_we=1, rd_addr=3 in cycle 2; instr_ready=1 in cycle 3.
REQ-034 LDR rd=4 imm15=0x7FFC, mem_ack on 3rd MEM cycle -> imm=0xFFFFFFFC, mem_req high 3 cycles, mem_we=0, then reg_we=1 for 1 cycle.
REQ-035 JGT with flags=0b0101 (N=1, V=1, Z=0) -> pc_load=1 in cycle 1; with flags=0b1000 -> pc_load=0; instr_ready=1 in cycle 2 either way.
REQ-036 op=5 -> err=1 for one cycle; reg_we, mem_req and alu_ctrl stay 0; instr_ready stays 1.
REQ-037 rst pulse during STR MEM -> mem_req=0 in the same cycle; FSM in IDLE after release; no write is issued.
REQ-038 With CTRL_MEM_TIMEOUT_EN: STR, mem_ack held 0 -> mem_req high exactly 16 cycles, then err=1 for one cycle and instr_ready=1.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: decodes one instruction at a time and sequences EXEC / MEM / WB for the datapath.
// Latency: ALU op 2 cycles (EXEC, WB), jump 1 cycle, LDR/STR 1 + MEM wait (+ WB for LDR).
// Backpressure: instr_ready is high only while idle; MEM holds mem_req until mem_ack is seen.
//
// Ports:
//   clk, rst                 single clock, asynchronous active-high reset
//   instr_valid/instr_ready  instruction handshake; instr = op[31:27] rd[26:23] rs1[22:19] rs2[18:15] imm15[14:0]
//   flags                    registered ALU flags {Z, N, C, V}
//   alu_ctrl, alu_src_imm    ALU operation and operand-B select
//   rd/rs1/rs2_addr, imm     register-file addresses and sign-extended immediate (N bits, N >= 16)
//   reg_we                   register-file write enable (suppressed for r0)
//   mem_req, mem_we, mem_ack data-memory request / store flag / completion
//   pc_load                  branch taken this cycle
//   err                      one-cycle pulse on illegal opcode or memory timeout
//
// Configuration: define CTRL_MEM_TIMEOUT_EN to abandon a memory access after 16 MEM cycles
// without mem_ack (err pulse, no writeback). Without it MEM waits indefinitely.
module control_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         instr_valid,
  input  logic [31:0]  instr,
  output logic         instr_ready,
  input  logic [3:0]   flags,
  output logic [4:0]   alu_ctrl,
  output logic [3:0]   rd_addr,
  output logic [3:0]   rs1_addr,
  output logic [3:0]   rs2_addr,
  output logic [N-1:0] imm,
  output logic         alu_src_imm,
  output logic         reg_we,
  output logic         mem_req,
  output logic         mem_we,
  input  logic         mem_ack,
  output logic         pc_load,
  output logic         err
);

  localparam logic [4:0] OP_LDR = 5'd17;
  localparam logic [4:0] OP_STR = 5'd19;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MEM,
    ST_WB
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [4:0]  alu_ctrl_q, alu_ctrl_d;
  logic        alu_src_imm_q, alu_src_imm_d;
  logic        reg_we_q, reg_we_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic        err_q, err_d;
  logic [4:0]  op_q;
  logic [4:0]  op_d;
  logic        flag_c_unused;

`ifdef CTRL_MEM_TIMEOUT_EN
  logic [3:0]  tmo_cnt_q, tmo_cnt_d;
`endif

  assign op_q = instr_q[31:27];
  assign op_d = instr_d[31:27];

  // Carry is not consulted by any branch condition.
  assign flag_c_unused = flags[1];

  function automatic logic op_legal(input logic [4:0] op);
    case (op)
      5'd1, 5'd2, 5'd3, 5'd4, 5'd9, 5'd10, 5'd11, 5'd12,
      5'd17, 5'd19, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30: op_legal = 1'b1;
      default:                                                 op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic op_jump(input logic [4:0] op);
    op_jump = (op >= 5'd25) && (op <= 5'd30);
  endfunction

  function automatic logic op_mem(input logic [4:0] op);
    op_mem = (op == OP_LDR) || (op == OP_STR);
  endfunction

  function automatic logic jump_taken(input logic [4:0] op, input logic z, input logic n,
                                      input logic v);
    case (op)
      5'd25:   jump_taken = z;
      5'd26:   jump_taken = !z;
      5'd27:   jump_taken = !z && (n == v);
      5'd28:   jump_taken = (n == v);
      5'd29:   jump_taken = (n != v);
      5'd30:   jump_taken = z || (n != v);
      default: jump_taken = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    err_d   = 1'b0;
`ifdef CTRL_MEM_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // Illegal opcodes are rejected without latching, so the held fields stay untouched.
        if (instr_valid) begin
          if (op_legal(instr[31:27])) begin
            instr_d = instr;
            state_d = ST_EXEC;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        if (op_jump(op_q)) begin
          state_d = ST_IDLE;
        end else if (op_mem(op_q)) begin
          state_d = ST_MEM;
`ifdef CTRL_MEM_TIMEOUT_EN
          tmo_cnt_d = 4'd0;
`endif
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          if (op_q == OP_STR) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WB;
          end
        end
`ifdef CTRL_MEM_TIMEOUT_EN
        // Count value 15 marks the 16th MEM cycle; an ack in that cycle still wins.
        else if (tmo_cnt_q == 4'd15) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 4'd1;
        end
`endif
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered outputs are computed for the state being entered so they line up with it.
    alu_ctrl_d    = 5'd0;
    alu_src_imm_d = 1'b0;
    if (state_d != ST_IDLE) begin
      alu_ctrl_d    = op_d;
      alu_src_imm_d = op_mem(op_d) || op_jump(op_d);
    end
    mem_req_d = (state_d == ST_MEM);
    mem_we_d  = (state_d == ST_MEM) && (op_d == OP_STR);
    reg_we_d  = (state_d == ST_WB) && (instr_d[26:23] != 4'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      instr_q       <= 32'd0;
      alu_ctrl_q    <= 5'd0;
      alu_src_imm_q <= 1'b0;
      reg_we_q      <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      err_q         <= 1'b0;
`ifdef CTRL_MEM_TIMEOUT_EN
      tmo_cnt_q     <= 4'd0;
`endif
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      alu_ctrl_q    <= alu_ctrl_d;
      alu_src_imm_q <= alu_src_imm_d;
      reg_we_q      <= reg_we_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      err_q         <= err_d;
`ifdef CTRL_MEM_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
`endif
    end
  end

  // Gated by rst so the handshake is closed for the whole reset window.
  assign instr_ready = (state_q == ST_IDLE) && !rst;

  // Flags are already registered upstream, so the branch decision is made in EXEC itself.
  assign pc_load = (state_q == ST_EXEC) && jump_taken(op_q, flags[3], flags[2], flags[0]);

  assign alu_ctrl    = alu_ctrl_q;
  assign alu_src_imm = alu_src_imm_q;
  assign reg_we      = reg_we_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign err         = err_q;
  assign rd_addr     = instr_q[26:23];
  assign rs1_addr    = instr_q[22:19];
  assign rs2_addr    = instr_q[18:15];
  assign imm         = {{(N-15){instr_q[14]}}, instr_q[14:0]};

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [3:0]  flags;
  logic [4:0]  alu_ctrl;
  logic [3:0]  rd_addr, rs1_addr, rs2_addr;
  logic [31:0] imm;
  logic        alu_src_imm, reg_we, mem_req, mem_we, mem_ack, pc_load, err;

  int n_checks = 0;
  int n_fail   = 0;

  control_unit #(.N(32)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .flags(flags), .alu_ctrl(alu_ctrl), .rd_addr(rd_addr), .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr), .imm(imm), .alu_src_imm(alu_src_imm), .reg_we(reg_we),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .pc_load(pc_load), .err(err)
  );

  always #5 clk = ~clk;

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam int MAXK = 20;
`else
  localparam int MAXK = 6;
`endif

  // Expected outputs for one cycle; ack is what the bench drives on mem_ack that cycle.
  typedef struct packed {
    bit        ready;
    bit [4:0]  alu;
    bit        chk_addr;
    bit [3:0]  rd;
    bit [3:0]  rs1;
    bit [3:0]  rs2;
    bit [31:0] imm;
    bit        src;
    bit        reg_we;
    bit        mem_req;
    bit        mem_we;
    bit        jmp;
    bit        err;
    bit        ack;
  } exp_t;

  exp_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [3:0] rs2,
                                     input logic [14:0] i15);
    return {op, rd, rs1, rs2, i15};
  endfunction

  function automatic bit legal(input logic [4:0] op);
    return op inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd9, 5'd10, 5'd11, 5'd12, 5'd17, 5'd19,
                      [5'd25:5'd30]};
  endfunction

  function automatic bit is_jump(input logic [4:0] op);
    return op inside {[5'd25:5'd30]};
  endfunction

  function automatic bit taken(input logic [4:0] op, input logic [3:0] f);
    bit z, n, v;
    z = f[3]; n = f[2]; v = f[0];
    case (op)
      5'd25: return z;
      5'd26: return !z;
      5'd27: return !z && (n == v);
      5'd28: return n == v;
      5'd29: return n != v;
      5'd30: return z || (n != v);
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t idle_rec(input bit e);
    exp_t r;
    r = '0;
    r.ready = 1'b1;
    r.err   = e;
    return r;
  endfunction

  // Expand an accepted instruction into its cycle-by-cycle output timeline.
  task automatic plan(input logic [31:0] ins);
    exp_t b, m;
    logic [4:0]  op;
    logic [14:0] i15;
    int k;
    bit tmo;
    op  = ins[31:27];
    i15 = ins[14:0];
    if (!legal(op)) begin
      q.push_back(idle_rec(1'b1));
      return;
    end
    b = '0;
    b.alu      = op;
    b.chk_addr = 1'b1;
    b.rd       = ins[26:23];
    b.rs1      = ins[22:19];
    b.rs2      = ins[18:15];
    b.imm      = 32'(int'($signed(i15)));
    b.src      = (op == 5'd17) || (op == 5'd19) || is_jump(op);
    m = b;
    m.jmp = is_jump(op);
    q.push_back(m);
    if (is_jump(op)) return;
    if (op == 5'd17 || op == 5'd19) begin
      k   = $urandom_range(1, MAXK);
      tmo = (k > 16);
      if (tmo) k = 16;
      for (int i = 1; i <= k; i++) begin
        m = b;
        m.mem_req = 1'b1;
        m.mem_we  = (op == 5'd19);
        m.ack     = !tmo && (i == k);
        q.push_back(m);
      end
      if (tmo) begin
        q.push_back(idle_rec(1'b1));
        return;
      end
      if (op == 5'd19) return;
    end
    m = b;
    m.reg_we = (b.rd != 4'd0);
    q.push_back(m);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] op;
    logic [4:0] legal_ops [16];
    legal_ops = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd9, 5'd10, 5'd11, 5'd12, 5'd17, 5'd19,
                  5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30};
    if ($urandom_range(0, 9) < 7) op = legal_ops[$urandom_range(0, 15)];
    else                          op = 5'($urandom);
    return mk(op, ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom), 4'($urandom),
              4'($urandom), 15'($urandom));
  endfunction

  task automatic send(input logic [31:0] ins);
    instr_valid = 1'b1;
    instr       = ins;
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  initial begin
    exp_t e;
    logic [3:0] fl;
    int cnt;

    rst = 1'b1; instr_valid = 1'b0; instr = '0; flags = '0; mem_ack = 1'b0;

    // Reset: everything low, valid instructions ignored.
    @(negedge clk);
    instr_valid = 1'b1; instr = mk(5'd1, 4'd3, 4'd1, 4'd2, 15'h7FFF);
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", instr_ready, 0);
    check("rst_alu", alu_ctrl, 0);
    check("rst_regwe", reg_we, 0);
    check("rst_memreq", mem_req, 0);
    check("rst_rd", rd_addr, 0);
    check("rst_imm", imm, 0);
    check("rst_err", err, 0);
    instr_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", instr_ready, 1);

    // ADD r3 = r1 + r2
    send(mk(5'd1, 4'd3, 4'd1, 4'd2, 15'd0));
    @(negedge clk);
    check("add_c1_alu", alu_ctrl, 1);
    check("add_c1_ready", instr_ready, 0);
    check("add_c1_src", alu_src_imm, 0);
    @(negedge clk);
    check("add_c2_regwe", reg_we, 1);
    check("add_c2_rd", rd_addr, 3);
    @(negedge clk);
    check("add_c3_ready", instr_ready, 1);
    check("add_c3_regwe", reg_we, 0);

    // LDR r4, ack on third MEM cycle
    send(mk(5'd17, 4'd4, 4'd0, 4'd0, 15'h7FFC));
    @(negedge clk);
    check("ldr_imm", imm, 32'hFFFF_FFFC);
    check("ldr_src", alu_src_imm, 1);
    check("ldr_c1_memreq", mem_req, 0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      mem_ack = (i == 3);
      #1;
      check("ldr_memreq", mem_req, 1);
      check("ldr_memwe", mem_we, 0);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    check("ldr_wb_regwe", reg_we, 1);
    check("ldr_wb_memreq", mem_req, 0);
    check("ldr_wb_rd", rd_addr, 4);
    @(negedge clk);
    check("ldr_after_regwe", reg_we, 0);
    check("ldr_after_ready", instr_ready, 1);

    // JGT taken (N=V, Z=0) and not taken (Z=1)
    flags = 4'b0101;
    send(mk(5'd27, 4'd0, 4'd0, 4'd0, 15'd8));
    @(negedge clk);
    check("jgt_taken_pc", pc_load, 1);
    @(negedge clk);
    check("jgt_taken_ready", instr_ready, 1);
    check("jgt_taken_pc_off", pc_load, 0);
    flags = 4'b1000;
    send(mk(5'd27, 4'd0, 4'd0, 4'd0, 15'd8));
    @(negedge clk);
    check("jgt_nt_pc", pc_load, 0);
    @(negedge clk);
    check("jgt_nt_ready", instr_ready, 1);

    // Illegal opcode 5
    send(mk(5'd5, 4'd7, 4'd0, 4'd0, 15'd0));
    @(negedge clk);
    check("ill_err", err, 1);
    check("ill_ready", instr_ready, 1);
    check("ill_regwe", reg_we, 0);
    check("ill_memreq", mem_req, 0);
    check("ill_alu", alu_ctrl, 0);
    @(negedge clk);
    check("ill_err_off", err, 0);
    check("ill_regwe2", reg_we, 0);

    // Reset in the middle of a STR memory access
    send(mk(5'd19, 4'd2, 4'd1, 4'd0, 15'd4));
    @(negedge clk);
    @(negedge clk);
    check("str_memreq", mem_req, 1);
    check("str_memwe", mem_we, 1);
    rst = 1'b1;
    #1;
    check("str_rst_memreq", mem_req, 0);
    check("str_rst_memwe", mem_we, 0);
    check("str_rst_ready", instr_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("str_rel_ready", instr_ready, 1);
    check("str_rel_memreq", mem_req, 0);
    check("str_rel_regwe", reg_we, 0);

`ifdef CTRL_MEM_TIMEOUT_EN
    // STR with no ack: 16 MEM cycles then an error pulse
    mem_ack = 1'b0;
    send(mk(5'd19, 4'd1, 4'd2, 4'd0, 15'd0));
    @(negedge clk);
    @(negedge clk);
    cnt = 0;
    while (mem_req === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("tmo_req_cycles", cnt, 16);
    check("tmo_err", err, 1);
    check("tmo_ready", instr_ready, 1);
    @(negedge clk);
    check("tmo_err_off", err, 0);
`endif

    // Random traffic against the timeline model
    instr_valid = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      if (q.size() > 0) e = q.pop_front();
      else              e = idle_rec(1'b0);
      fl      = 4'($urandom);
      flags   = fl;
      mem_ack = e.mem_req ? e.ack : 1'($urandom);
      #1;
      check("r_ready", instr_ready, e.ready);
      check("r_alu", alu_ctrl, e.alu);
      check("r_src", alu_src_imm, e.src);
      check("r_regwe", reg_we, e.reg_we);
      check("r_memreq", mem_req, e.mem_req);
      check("r_memwe", mem_we, e.mem_we);
      check("r_err", err, e.err);
      check("r_pcload", pc_load, e.jmp && taken(e.alu, fl));
      if (e.chk_addr) begin
        check("r_rd", rd_addr, e.rd);
        check("r_rs1", rs1_addr, e.rs1);
        check("r_rs2", rs2_addr, e.rs2);
        check("r_imm", imm, e.imm);
      end
      instr_valid = ($urandom_range(0, 2) != 0);
      instr       = rand_instr();
      if (e.ready && instr_valid) plan(instr);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
